// File: rtl/mem_responder.sv
// Fixed-latency responder for the mem_req/mem_ready handshake over a DEPTH x DATA_W array.
// Latency: mem_req accepted at edge k -> one-cycle mem_ready pulse in the cycle after edge k+LATENCY.
// Backpressure: a single request is in flight; mem_req must go low once before the next is accepted.
// Build option: MEM_RESPONDER_WRITE_EN enables the write port; without it the array is read-only.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic              mem_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  // WAIT always lasts at least one cycle, so the counter runs from LATENCY-1
  // down to zero and RESP is entered exactly LATENCY edges after acceptance.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              commit;
  logic              accept;

  assign accept = (state == IDLE) && mem_req;
  // The access happens on the edge that moves WAIT -> RESP.
  assign commit = (state == WAIT) && (cnt == 4'd0);

`ifdef MEM_RESPONDER_WRITE_EN
  logic [DATA_W-1:0] wdata_q;

  // Capture write data at acceptance; later changes on wdata are ignored.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      wdata_q <= wdata;
    end
  end

  // Storage write port; gated by rst_n so a write caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && commit && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end
`else
  // Read-only build: write data is accepted on the port but never stored.
  logic unused_wdata;
  assign unused_wdata = ^wdata;
`endif

  // Handshake FSM, request latch, latency counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      mem_ready <= 1'b0;
      data_out  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q <= addr;
            we_q   <= we;
            cnt    <= CNT_LOAD;
            state  <= WAIT;
            busy   <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            mem_ready <= 1'b1;
            // Writes (or suppressed writes) leave data_out untouched.
            if (!we_q) begin
              data_out <= mem[addr_q];
            end
          end
        end
        RESP: begin
          state     <= RELEASE;
          mem_ready <= 1'b0;
        end
        default: begin
          // RELEASE: a request still held high is never re-accepted.
          if (!mem_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: timeline model plus literal directed checks.
// Latency: exercised at LAT=2 directed, then randomized traffic.
// Backpressure: requester holds mem_req for random cycles after mem_ready, or drops it early.
module tb_mem_responder;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_req;
  logic [7:0] addr;
  logic       we;
  logic [7:0] wdata;
  logic       mem_ready;
  logic [7:0] data_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .addr(addr), .we(we),
    .wdata(wdata), .mem_ready(mem_ready), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-request timeline. A request accepted at edge acc
  // completes at edge acc+LAT (pulse in the following cycle) and the block is
  // idle again after the first edge >= acc+LAT+2 that samples mem_req low.
  logic [7:0] mdl_mem [256];
  int         n = 0;
  bit         m_active = 0;
  int         acc = 0;
  logic [7:0] a_l, d_l;
  logic       w_l;
  logic       exp_ready = 0, exp_busy = 0;
  logic [7:0] exp_data = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active  = 0;
      exp_ready = 0;
      exp_busy  = 0;
      exp_data  = 8'h00;
    end else begin
      exp_ready = 0;
      if (!m_active) begin
        if (mem_req) begin
          m_active = 1;
          acc = n;
          a_l = addr;
          w_l = we;
          d_l = wdata;
        end
      end else if (n == acc + LAT) begin
        exp_ready = 1;
        if (!w_l) exp_data = mdl_mem[a_l];
`ifdef MEM_RESPONDER_WRITE_EN
        else mdl_mem[a_l] = d_l;
`endif
      end else if (n >= acc + LAT + 2 && !mem_req) begin
        m_active = 0;
      end
      exp_busy = m_active;
    end
    n++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (n > 0) begin
      chk("cyc_mem_ready", mem_ready, exp_ready);
      chk("cyc_busy", busy, exp_busy);
      chk("cyc_data_out", data_out, exp_data);
    end
  end

  // One full request; counts mem_ready pulses seen by the requester.
  task automatic do_req(input logic [7:0] a, input logic w, input logic [7:0] d,
                        input int hold, input bit abandon, output int pulses);
    bit seen;
    bit idle;
    pulses = 0;
    seen = 0;
    idle = 0;
    @(negedge clk);
    addr = a; we = w; wdata = d; mem_req = 1'b1;
    @(negedge clk);
    addr = 8'($urandom); we = 1'($urandom); wdata = 8'($urandom);
    if (abandon) mem_req = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (mem_ready) begin
        seen = 1;
        pulses++;
      end else begin
        @(negedge clk);
      end
    end
    chk("pulse_timeout", seen, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (mem_ready) pulses++;
    end
    mem_req = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (mem_ready) pulses++;
      if (!busy) idle = 1;
    end
    chk("idle_timeout", idle, 1);
  endtask

  int p;
  logic [7:0] wr_exp;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mdl_mem[i] = 8'($urandom);
    end
    mdl_mem[8'h10] = 8'hA5;
    mdl_mem[8'h20] = 8'h00;
    mdl_mem[8'h05] = 8'h11;
    mdl_mem[8'hFF] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      dut.mem[i] = mdl_mem[i];
    end

    // Reset held for 3 cycles with a request pending.
    rst_n = 1'b0; mem_req = 1'b1; addr = 8'h10; we = 1'b0; wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", mem_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_out, 0);

    // Basic read of 0x10: accepted on the first edge after reset release.
    rst_n = 1'b1;
    @(negedge clk);                         // after edge 0
    chk("rd_accept_busy", busy, 1);
    chk("rd_e0_ready", mem_ready, 0);
    @(negedge clk);                         // after edge 1
    chk("rd_e1_ready", mem_ready, 0);
    @(negedge clk);                         // after edge 2
    chk("rd_e2_ready", mem_ready, 1);
    chk("rd_data_a5", data_out, 8'hA5);
    chk("mdl_data_a5", exp_data, 8'hA5);
    mem_req = 1'b0;
    @(negedge clk);                         // after edge 3
    chk("rd_e3_ready", mem_ready, 0);
    chk("rd_e3_busy", busy, 1);
    @(negedge clk);                         // after edge 4
    chk("rd_e4_busy", busy, 0);

`ifdef MEM_RESPONDER_WRITE_EN
    wr_exp = 8'h3C;
`else
    wr_exp = 8'h00;
`endif

    // Write 0xFF then read it back; data_out must survive the write.
    do_req(8'hFF, 1'b1, 8'h3C, 0, 0, p);
    chk("wr_ff_pulses", p, 1);
    chk("wr_keeps_data", data_out, 8'hA5);
    do_req(8'hFF, 1'b0, 8'h00, 0, 0, p);
    chk("rd_ff_data", data_out, wr_exp);

    // Write 0x20 (holds 0x00) then read.
    do_req(8'h20, 1'b1, 8'h3C, 0, 0, p);
    chk("wr_20_pulses", p, 1);
    do_req(8'h20, 1'b0, 8'h00, 0, 0, p);
    chk("rd_20_data", data_out, wr_exp);

    // Held request: one pulse only.
    do_req(8'h10, 1'b0, 8'h00, 5, 0, p);
    chk("held_pulses", p, 1);
    chk("held_data", data_out, 8'hA5);

    // Abandoned request: still one pulse.
    do_req(8'h05, 1'b0, 8'h00, 0, 1, p);
    chk("abandon_pulses", p, 1);
    chk("abandon_data", data_out, 8'h11);

    // Reset during WAIT of a write of 0x77 to 0x05.
    @(negedge clk);
    addr = 8'h05; we = 1'b1; wdata = 8'h77; mem_req = 1'b1;
    @(negedge clk);
    chk("rstmid_busy_before", busy, 1);
    rst_n = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", mem_ready, 0);
    @(negedge clk);
    chk("rstmid_ready2", mem_ready, 0);
    rst_n = 1'b1;
    do_req(8'h05, 1'b0, 8'h00, 0, 0, p);
    chk("rstmid_rd_05", data_out, 8'h11);

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      do_req(8'($urandom_range(0, 15)), 1'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), p);
      chk("rand_pulses", p, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
